pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline; works alongside the EXE-stage operand forwarding logic.

---
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: memory freeze, branch flush,
// multi-cycle mul/div occupancy and load-use bubbles, plus saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             exe_mem_read,
    input  logic [4:0]       exe_rd_addr,
    input  logic             exe_branch_taken,
    input  logic             exe_muldiv_start,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_exe_write,
    output logic             id_exe_flush,
    output logic             exe_mem_write,
    output logic             exe_mem_flush,
    output logic             mem_wb_write,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, MULDIV} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             skip_q, skip_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic mem_freeze;
    logic branch;
    logic load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    assign mem_freeze = imem_stall | dmem_stall;
    assign branch     = exe_branch_taken && (state_q == RUN);
    assign load_use   = exe_mem_read && (exe_rd_addr != 5'd0) &&
                        ((id_use_rs1 && (id_rs1_addr == exe_rd_addr)) ||
                         (id_use_rs2 && (id_rs2_addr == exe_rd_addr)));

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_exe_write  = 1'b1;
        exe_mem_write = 1'b1;
        mem_wb_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        exe_mem_flush = 1'b0;
        if (rst) begin
            pc_write      = 1'b0;
            if_id_flush   = 1'b1;
            id_exe_flush  = 1'b1;
            exe_mem_flush = 1'b1;
        end else if (mem_freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_write  = 1'b0;
            exe_mem_write = 1'b0;
            mem_wb_write  = 1'b0;
        end else if (branch) begin
            // The ID instruction is wrong-path, so any load-use on it is moot.
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (state_q == MULDIV) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_write  = 1'b0;
            exe_mem_flush = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_exe_flush = 1'b1;
        end
    end

    assign muldiv_busy = (state_q == MULDIV) && !rst;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        skip_d         = skip_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!mem_freeze) begin
            skip_d = 1'b0;
            case (state_q)
                RUN: begin
                    // skip_q blocks re-launching the op that just finished.
                    if (exe_muldiv_start && !exe_branch_taken && !skip_q) begin
                        state_d = MULDIV;
                        cnt_d   = 4'(MULDIV_LAT - 2);
                    end
                end
                MULDIV: begin
                    if (cnt_q == 4'd0) begin
                        state_d = RUN;
                        skip_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = RUN;
            endcase
            if (branch) flush_count_d = sat_inc(flush_count_q);
        end
        if (!pc_write) stall_cycles_d = sat_inc(stall_cycles_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= 4'd0;
            skip_q         <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            skip_q         <= skip_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with small counters so saturation is reachable.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1_addr, id_rs2_addr, exe_rd_addr;
    logic             id_use_rs1, id_use_rs2, exe_mem_read;
    logic             exe_branch_taken, exe_muldiv_start, imem_stall, dmem_stall;
    logic             pc_write, if_id_write, if_id_flush, id_exe_write, id_exe_flush;
    logic             exe_mem_write, exe_mem_flush, mem_wb_write, muldiv_busy;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int total = 0;
    int fails = 0;

    pipeline_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .exe_mem_read(exe_mem_read), .exe_rd_addr(exe_rd_addr),
        .exe_branch_taken(exe_branch_taken), .exe_muldiv_start(exe_muldiv_start),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_exe_write(id_exe_write), .id_exe_flush(id_exe_flush),
        .exe_mem_write(exe_mem_write), .exe_mem_flush(exe_mem_flush),
        .mem_wb_write(mem_wb_write), .muldiv_busy(muldiv_busy),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Writes packed as {pc, if_id, id_exe, exe_mem, mem_wb}; flushes as {if_id, id_exe, exe_mem}.
    function automatic logic [31:0] wr();
        return {27'd0, pc_write, if_id_write, id_exe_write, exe_mem_write, mem_wb_write};
    endfunction
    function automatic logic [31:0] fl();
        return {29'd0, if_id_flush, id_exe_flush, exe_mem_flush};
    endfunction

    task automatic idle();
        rst = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        exe_mem_read = 0; exe_rd_addr = 0; exe_branch_taken = 0; exe_muldiv_start = 0;
        imem_stall = 0; dmem_stall = 0;
    endtask

    // Inputs change on the falling edge; combinational outputs are checked 1 ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        idle();
        // Reset held two cycles
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk("rst_writes", wr(), 32'b01111);
            chk("rst_flush", fl(), 32'b111);
            chk("rst_busy", muldiv_busy, 0);
        end
        idle(); cyc(); #1;
        chk("post_rst_writes", wr(), 32'b11111);
        chk("post_rst_flush", fl(), 32'b000);
        chk("post_rst_stall", stall_cycles, 0);
        chk("post_rst_flushcnt", flush_count, 0);

        // Load-use on rs2
        cyc(); exe_mem_read = 1; exe_rd_addr = 5; id_rs2_addr = 5; id_use_rs2 = 1; #1;
        chk("lu_writes", wr(), 32'b00111);
        chk("lu_flush", fl(), 32'b010);
        cyc(); idle(); #1;
        chk("lu_release", wr(), 32'b11111);
        chk("lu_stall", stall_cycles, 1);

        // Same with rd = x0: no hazard
        cyc(); exe_mem_read = 1; exe_rd_addr = 0; id_rs2_addr = 0; id_use_rs2 = 1; #1;
        chk("x0_writes", wr(), 32'b11111);
        chk("x0_flush", fl(), 32'b000);
        cyc(); idle(); #1;
        chk("x0_stall", stall_cycles, 1);

        // Branch plus load-use in the same cycle
        cyc(); exe_mem_read = 1; exe_rd_addr = 5; id_rs2_addr = 5; id_use_rs2 = 1;
        exe_branch_taken = 1; #1;
        chk("br_writes", wr(), 32'b11111);
        chk("br_flush", fl(), 32'b110);
        cyc(); idle(); #1;
        chk("br_flushcnt", flush_count, 1);
        chk("br_stall", stall_cycles, 1);

        // Mul/div, start held as a level until the op leaves EXE
        cyc(); exe_muldiv_start = 1; #1;
        chk("md_start_busy", muldiv_busy, 0);
        chk("md_start_writes", wr(), 32'b11111);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("md_busy", muldiv_busy, 1);
            chk("md_writes", wr(), 32'b00011);
            chk("md_flush", fl(), 32'b001);
        end
        cyc(); #1;
        chk("md_exit_busy", muldiv_busy, 0);
        chk("md_exit_writes", wr(), 32'b11111);
        chk("md_exit_flush", fl(), 32'b000);
        cyc(); idle(); #1;
        chk("md_no_restart", muldiv_busy, 0);
        chk("md_stall", stall_cycles, 4);

        // Mul/div with a 2-cycle dmem freeze in the middle
        cyc(); exe_muldiv_start = 1; #1;
        chk("mdf_start_busy", muldiv_busy, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(); dmem_stall = (i == 1 || i == 2); #1;
            chk("mdf_busy", muldiv_busy, 1);
            if (i == 1 || i == 2) begin
                chk("mdf_freeze_writes", wr(), 32'b00000);
                chk("mdf_freeze_flush", fl(), 32'b000);
            end else begin
                chk("mdf_writes", wr(), 32'b00011);
            end
        end
        cyc(); #1;
        chk("mdf_exit_busy", muldiv_busy, 0);
        cyc(); idle(); #1;
        chk("mdf_stall", stall_cycles, 9);

        // Reset in the middle of a mul/div
        cyc(); exe_muldiv_start = 1; #1;
        cyc(); #1;
        chk("mdr_busy", muldiv_busy, 1);
        cyc(); rst = 1; #1;
        chk("mdr_rst_busy", muldiv_busy, 0);
        chk("mdr_rst_flush", fl(), 32'b111);
        cyc(); idle(); #1;
        chk("mdr_after_busy", muldiv_busy, 0);
        chk("mdr_after_writes", wr(), 32'b11111);
        chk("mdr_after_stall", stall_cycles, 0);
        chk("mdr_after_flushcnt", flush_count, 0);

        // Counter saturation: 18 freeze cycles and 17 branches on 4-bit counters
        for (int i = 0; i < 18; i++) begin
            cyc(); imem_stall = (i < 9); dmem_stall = (i >= 9); #1;
        end
        for (int i = 0; i < 17; i++) begin
            cyc(); imem_stall = 0; dmem_stall = 0; exe_branch_taken = 1; #1;
        end
        cyc(); idle(); #1;
        chk("sat_stall", stall_cycles, 15);
        chk("sat_flushcnt", flush_count, 15);
        cyc(); dmem_stall = 1; #1;
        cyc(); idle(); #1;
        chk("sat_stall_hold", stall_cycles, 15);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
